inv_sub_bytes_iter: RTL and testbench
=====================================

// Module: inv_sub_bytes_iter
// PURPOSE
//  Iterative AES InvSubBytes engine for the decryption datapath. Accepts one 128-bit state,
//  replaces every byte b with InvSBox(b), LANES bytes per cycle, and returns the result
//  through a valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the
//  inverse cipher and is the decrypt counterpart of the forward SBox lookup.
// PARAMETERS
//  LANES  4  bytes substituted per cycle; legal 1,2,4,8,16; any other value fails elaboration
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous reset, active-high
//  in_valid   in   1    state_in is valid
//  in_ready   out  1    engine can accept a state
//  state_in   in   128  input state; byte i = state_in[127-8i -: 8], so byte 0 = [127:120]
//  out_valid  out  1    state_out holds a completed result
//  out_ready  in   1    downstream accepts state_out
//  state_out  out  128  substituted state, same byte order as state_in
//  busy       out  1    high in BUSY or DONE
//  check_err  out  1    present only with INV_SBOX_ROUNDTRIP_CHECK_EN
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, cnt=0, data reg=0, state_out=0, out_valid=0,
//    busy=0, in_ready=1, check_err=0. Reset mid-operation discards the state in flight.
//  - Define N = 16/LANES.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid at an edge: load state_in into the data reg, cnt=0,
//      go to BUSY.
//    BUSY: in_ready=0. Each edge replaces bytes cnt*LANES .. cnt*LANES+LANES-1 with
//      their InvSBox values, then cnt++. The edge that processes cnt==N-1 moves to DONE
//      and clears cnt.
//    DONE: out_valid=1 and state_out=data reg, held stable until out_ready.
//      On out_valid && out_ready, go to IDLE; out_valid drops on the next cycle.
//  - Latency: a state accepted at edge k gives out_valid=1 after edge k+N
//    (LANES=16: 1 edge; LANES=4: 4 edges). Throughput is one state per N+2 cycles.
//  - in_ready is a pure function of the FSM state. It never depends on in_valid, and
//    in_valid is ignored outside IDLE.
//  - state_out is registered and keeps its last value after leaving DONE.
//  - InvSBox is the FIPS-197 inverse table (256 entries, fully specified, no X), for
//    example 63->00, 7c->01, 00->52, 16->ff, ed->53. One combinational lookup per lane.
//  - out_ready held high in DONE completes the handshake on the first DONE cycle.
//    out_ready low holds DONE indefinitely.
// CONFIGURATION
//  INV_SBOX_ROUNDTRIP_CHECK_EN defined:
//    - Keeps a copy of the accepted input and adds port check_err.
//    - On entry to DONE, computes SBox(state_out) for all 16 bytes with the forward
//      table and compares it to the copy.
//    - check_err is registered, valid while out_valid=1, 1 on any byte mismatch, and
//      cleared on the return to IDLE.
//  Not defined: no copy register, no forward tables, no check_err port. Datapath timing
//    is identical in both builds.
// TESTING
//  1. LANES=4; apply rst mid-BUSY -> out_valid=0 and in_ready=1 immediately; no stale
//     output after rst is released.
//  2. state_in = 16 bytes of 63 -> state_out = 0 after 4 edges; out_valid on the 4th.
//  3. state_in = 637c777bf26b6fc53001672bfed7ab76 -> state_out = 000102..0f.
//  4. Hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable,
//     in_ready=0; in_valid pulses during BUSY and DONE are ignored.
//  5. LANES=16, back-to-back states 0016ed..00 and 16 bytes of 16, out_ready=1 ->
//     2 results of the form 52ff53..52 and all ff; each accept is N+2 cycles apart.
//  6. With INV_SBOX_ROUNDTRIP_CHECK_EN, sweep all 256 byte values -> check_err=0.
//     Force one table entry wrong -> check_err=1.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative AES InvSubBytes engine, LANES bytes per cycle
// Optional INV_SBOX_ROUNDTRIP_CHECK_EN adds a forward-SBox round-trip check on check_err.
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
  ,
  output logic         check_err
`endif
);
  localparam int N = 16 / LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Entry 0 sits in the top byte so a byte value indexes from the MSB end.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  out_q, out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = state_in;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[127 - 8*(int'(cnt_q)*LANES + l) -: 8] =
            inv_sbox(data_q[127 - 8*(int'(cnt_q)*LANES + l) -: 8]);
        end
        if (cnt_q == 4'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          out_d   = data_d;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign state_out = out_q;

`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = FWD_SBOX[2047 - 8*int'(s[127 - 8*i -: 8]) -: 8];
    end
    return r;
  endfunction

  logic [127:0] copy_q;
  logic         err_q;

  // The check is evaluated on the same edge that loads state_out, so it is valid with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      copy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid) copy_q <= state_in;
      if (state_q == S_BUSY && state_d == S_DONE) err_q <= (fwd_state(data_d) != copy_q);
      else if (state_q == S_DONE && state_d == S_IDLE) err_q <= 1'b0;
    end
  end

  assign check_err = err_q;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - directed bench for inv_sub_bytes_iter (LANES=4 and LANES=16)
module tb_inv_sub_bytes_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv4, ir4, ov4, or4, bz4;
  logic [127:0] si4, so4;
  logic         iv16, ir16, ov16, or16, bz16;
  logic [127:0] si16, so16;
`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
  logic         ce4, ce16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  inv_sub_bytes_iter #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .state_in(si4),
    .out_valid(ov4), .out_ready(or4), .state_out(so4), .busy(bz4)
`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
    , .check_err(ce4)
`endif
  );

  inv_sub_bytes_iter #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .state_in(si16),
    .out_valid(ov16), .out_ready(or16), .state_out(so16), .busy(bz16)
`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
    , .check_err(ce16)
`endif
  );

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;

  vec_t         vecs[7];
  logic [127:0] sweep_din;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [127:0] din, input logic [127:0] exp, input string name,
                       input bit chk_out);
    chk({name, " in_ready idle"}, 128'(ir4), 128'd1);
    iv4 = 1'b1;
    si4 = din;
    tick();
    iv4 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("%s out_valid edge%0d", name, e), 128'(ov4), (e == 4) ? 128'd1 : 128'd0);
    end
    if (chk_out) chk({name, " state_out"}, so4, exp);
`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
    chk({name, " check_err"}, 128'(ce4), 128'd0);
`endif
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk({name, " back to idle"}, {125'd0, ov4, bz4, ir4}, 128'd1);
  endtask

  initial begin
    vecs[0] = '{{16{8'h63}}, 128'h0, "all63"};
    vecs[1] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, "row0"};
    vecs[2] = '{128'hca82c97dfa5947f0add4a2af9ca472c0, 128'h101112131415161718191a1b1c1d1e1f, "row1"};
    vecs[3] = '{128'h8ca1890dbfe6426841992d0fb054bb16, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, "rowf"};
    vecs[4] = '{128'h0, {16{8'h52}}, "all00"};
    vecs[5] = '{128'h0016ed0016ed0016ed0016ed0016ed00, 128'h52ff5352ff5352ff5352ff5352ff5352, "mix"};
    vecs[6] = '{128'he0323a0a4906245cc2d3ac629195e479, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, "rowa"};

    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b0; si4 = '0;
    iv16 = 1'b0; or16 = 1'b0; si16 = '0;
    #12;
    chk("reset in_ready", 128'(ir4), 128'd1);
    chk("reset out_valid", 128'(ov4), 128'd0);
    chk("reset busy", 128'(bz4), 128'd0);
    chk("reset state_out", so4, 128'd0);
    chk("reset16 in_ready", 128'(ir16), 128'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 7; v++) send4(vecs[v].din, vecs[v].dout, vecs[v].name, 1'b1);

    // Backpressure in DONE, with in_valid held high throughout BUSY and DONE
    iv4 = 1'b1;
    si4 = vecs[1].din;
    tick();
    si4 = vecs[0].din;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("hold busy edge%0d", e), {126'd0, bz4, ir4}, 128'd2);
    end
    tick();
    chk("hold enter done", 128'(ov4), 128'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("hold c%0d flags", c), {125'd0, ov4, bz4, ir4}, 128'd6);
      chk($sformatf("hold c%0d state_out", c), so4, vecs[1].dout);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk("hold release flags", {125'd0, ov4, bz4, ir4}, 128'd1);
    chk("hold state_out kept", so4, vecs[1].dout);
    tick();
    chk("hold no stray accept", {125'd0, ov4, bz4, ir4}, 128'd1);

    // LANES=16 back-to-back with out_ready tied high
    or16 = 1'b1;
    chk("b2b idle", 128'(ir16), 128'd1);
    iv16 = 1'b1;
    si16 = vecs[5].din;
    tick();
    si16 = {16{8'h16}};
    chk("b2b accepted A", {126'd0, ov16, ir16}, 128'd0);
    tick();
    chk("b2b A valid", 128'(ov16), 128'd1);
    chk("b2b A data", so16, vecs[5].dout);
    tick();
    chk("b2b idle again", {126'd0, ov16, ir16}, 128'd1);
    tick();
    iv16 = 1'b0;
    chk("b2b accepted B", {126'd0, ov16, ir16}, 128'd0);
    tick();
    chk("b2b B valid", 128'(ov16), 128'd1);
    chk("b2b B data", so16, {16{8'hff}});
    tick();
    chk("b2b B done", 128'(ov16), 128'd0);
    chk("b2b B kept", so16, {16{8'hff}});
    or16 = 1'b0;

    // Asynchronous reset in the middle of BUSY
    iv4 = 1'b1;
    si4 = vecs[2].din;
    tick();
    iv4 = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst mid flags", {125'd0, ov4, bz4, ir4}, 128'd1);
    chk("rst mid state_out", so4, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post rst c%0d", c), {125'd0, ov4, bz4, ir4}, 128'd1);
    end
    send4(vecs[3].din, vecs[3].dout, "after rst", 1'b1);

`ifdef INV_SBOX_ROUNDTRIP_CHECK_EN
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) sweep_din[127 - 8*i -: 8] = 8'(16*j + i);
      send4(sweep_din, 128'd0, $sformatf("sweep%0d", j), 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
